rx_demux: RTL and testbench
===========================

// Module: rx_demux
// PURPOSE
//  Inbound counterpart of the sub-AFU Tx multiplexer: splits one CCI-P Rx port from the FIU/shim into
//  N_SUBAFUS per-sub-AFU Rx ports. Memory responses are routed by sub-AFU index tag bits in mdata.
//  MMIO requests are routed by address bits. Per-sub-AFU almFull merges the global FIU almFull with the
//  Tx-mux per-sub-AFU FIFO almFull. Fixed 2-cycle registered pipeline; no backpressure (CCI-P Rx has none).
// PARAMETERS
//  N_SUBAFUS     16  number of sub-AFUs (>=2; need not be a power of two)
//  MDATA_IDX_LSB 12  LSB of sub-AFU index field in hdr.mdata[15:0]; field = [MDATA_IDX_LSB +: LOG_N]
//  MMIO_IDX_LSB  12  LSB of sub-AFU index in MMIO dword address[15:0]; field = [MMIO_IDX_LSB +: LOG_N]
//  (LOG_N = $clog2(N_SUBAFUS); elaboration error if either field exceeds bit 15)
// PORTS
//  clk           in   1                  clock
//  reset         in   1                  synchronous, active-high reset
//  in            in   t_if_ccip_Rx       Rx from FIU/shim
//  tx_c0_almFull in   1 x [N_SUBAFUS]    per-sub-AFU c0 FIFO almostFull from Tx mux
//  tx_c1_almFull in   1 x [N_SUBAFUS]    per-sub-AFU c1 FIFO almostFull from Tx mux
//  out           out  t_if_ccip_Rx x [N] per-sub-AFU Rx
//  drop_cnt      out  16                 saturating count of dropped (unroutable) events
//  drop_err      out  1                  sticky: at least one event dropped since reset
// BEHAVIOUR
//  Reset: all out[i].c0/c1 valids and headers/data 0; out[i].c0TxAlmFull/c1TxAlmFull = 1 (block issue
//   until pipeline is live); drop_cnt=0; drop_err=0. Reset mid-stream discards any in-flight stage contents.
//  Pipeline: T1 registers `in` and decodes index per channel; T2 registers per-port outputs.
//   Event on `in` at cycle t appears on out[idx] at cycle t+2, all other ports show valid=0 that cycle.
//  c0 rspValid (mem read rsp, resp_type != eRSP_UMSG): idx = hdr.mdata[MDATA_IDX_LSB +: LOG_N];
//   delivered hdr has those index bits zeroed, all other hdr fields and data unchanged.
//  c0 rspValid with resp_type == eRSP_UMSG: broadcast to all N ports unchanged.
//  c1 rspValid (write rsp incl. packed/fence): idx from c1 hdr.mdata as above; index bits zeroed.
//  c0 mmioRdValid / mmioWrValid: idx = MMIO address[MMIO_IDX_LSB +: LOG_N]; delivered address has index
//   bits zeroed (local offset); tid, length, data unchanged. Exactly one port sees the request.
//  c0 and c1 independent: same-cycle c0 and c1 events to different (or the same) ports both delivered.
//  idx >= N_SUBAFUS (non-power-of-two N only): event dropped (no port valid), drop_cnt += 1
//   (+2 if c0 and c1 both drop same cycle), saturating at 16'hFFFF; drop_err set, cleared only by reset.
//   Host software must never issue MMIO to unmapped indices (no MMIO read response is generated here).
//  almFull: out[i].c0TxAlmFull = reg(in.c0TxAlmFull | tx_c0_almFull[i]); same for c1; 1-cycle latency.
//  Non-valid cycles: out[i].c0/c1 payload fields held at 0 (not stale) for waveform/assertion clarity.
// TESTING
//  1 c0 rd rsp mdata=16'h3005, N=16 -> out[3] c0.rspValid at t+2, mdata=16'h0005; ports !=3 valid=0.
//  2 same cycle c0 rsp mdata 16'h1001 and c1 rsp mdata 16'hE0AA -> out[1].c0 and out[14].c1 both at t+2.
//  3 MMIO wr addr 16'h2040 data=64'hDEAD -> out[2].mmioWrValid, addr 16'h0040, data kept; one port only.
//  4 UMsg c0 rsp -> all 16 ports rspValid at t+2, identical hdr/data.
//  5 N=12: c1 rsp mdata 16'hD000 -> no port valid, drop_cnt=1, drop_err=1; 70000 drops -> drop_cnt=16'hFFFF.
//  6 in.c0TxAlmFull=0, tx_c0_almFull[5]=1 -> only out[5].c0TxAlmFull=1 next cycle; reset asserted with
//    rsp in T1 -> rsp never delivered, all almFull=1 during reset, drop_cnt=0 after.

Source files
------------

// File: rtl/rx_demux.sv
// CCI-P Rx types plus a demultiplexer that fans one Rx port out to N sub-AFU Rx ports.
// Routing uses index bits in mdata (memory responses) or in the MMIO address (MMIO requests).
package ccip_if_pkg;
  localparam logic [3:0] eRSP_RDLINE = 4'h0;
  localparam logic [3:0] eRSP_UMSG   = 4'h4;
  localparam logic [3:0] eRSP_WRLINE = 4'h0;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  // MMIO requests reuse the c0 header bits; this overlay has the same width.
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module rx_demux
  import ccip_if_pkg::*;
#(
  parameter int N_SUBAFUS     = 16,
  parameter int MDATA_IDX_LSB = 12,
  parameter int MMIO_IDX_LSB  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  t_if_ccip_Rx          in,
  input  logic [N_SUBAFUS-1:0] tx_c0_almFull,
  input  logic [N_SUBAFUS-1:0] tx_c1_almFull,
  output t_if_ccip_Rx          out [N_SUBAFUS],
  output logic [15:0]          drop_cnt,
  output logic                 drop_err
);

  localparam int LOG_N = $clog2(N_SUBAFUS);
  localparam logic [LOG_N:0] N_W = N_SUBAFUS[LOG_N:0];
  localparam logic [15:0] MDATA_MASK = 16'(((1 << LOG_N) - 1) << MDATA_IDX_LSB);
  localparam logic [15:0] MMIO_MASK  = 16'(((1 << LOG_N) - 1) << MMIO_IDX_LSB);

  if (N_SUBAFUS < 2) begin : g_bad_n
    $error("rx_demux: N_SUBAFUS must be at least 2");
  end
  if (MDATA_IDX_LSB + LOG_N > 16) begin : g_bad_mdata
    $error("rx_demux: mdata index field exceeds bit 15");
  end
  if (MMIO_IDX_LSB + LOG_N > 16) begin : g_bad_mmio
    $error("rx_demux: MMIO index field exceeds bit 15");
  end

  t_ccip_c0_ReqMmioHdr c0_mmio_hdr;
  t_if_ccip_c0_Rx      c0_dec;
  t_if_ccip_c1_Rx      c1_dec;
  logic                c0_is_mmio;
  logic                c0_valid;
  logic                c0_bcast;
  logic                c0_drop;
  logic                c1_drop;
  logic [LOG_N-1:0]    c0_idx;
  logic [LOG_N-1:0]    c1_idx;
  logic [16:0]         drop_sum;

  t_if_ccip_c0_Rx      s1_c0;
  t_if_ccip_c1_Rx      s1_c1;
  logic                s1_c0_bcast;
  logic [LOG_N-1:0]    s1_c0_idx;
  logic [LOG_N-1:0]    s1_c1_idx;

  // Decode and strip the index field; dropped or idle channels carry an all-zero payload.
  always_comb begin
    c0_dec      = in.c0;
    c1_dec      = in.c1;
    c0_mmio_hdr = t_ccip_c0_ReqMmioHdr'(in.c0.hdr);
    c0_is_mmio  = in.c0.mmioRdValid | in.c0.mmioWrValid;
    c0_valid    = c0_is_mmio | in.c0.rspValid;
    c0_bcast    = in.c0.rspValid && (in.c0.hdr.resp_type == eRSP_UMSG);
    c0_idx      = c0_is_mmio ? c0_mmio_hdr.address[MMIO_IDX_LSB +: LOG_N]
                             : in.c0.hdr.mdata[MDATA_IDX_LSB +: LOG_N];
    c1_idx      = in.c1.hdr.mdata[MDATA_IDX_LSB +: LOG_N];
    c0_drop     = c0_valid && !c0_bcast && ({1'b0, c0_idx} >= N_W);
    c1_drop     = in.c1.rspValid && ({1'b0, c1_idx} >= N_W);

    if (c0_is_mmio) begin
      c0_mmio_hdr.address = c0_mmio_hdr.address & ~MMIO_MASK;
      c0_dec.hdr          = t_ccip_c0_RspMemHdr'(c0_mmio_hdr);
    end else if (!c0_bcast) begin
      c0_dec.hdr.mdata = in.c0.hdr.mdata & ~MDATA_MASK;
    end
    c1_dec.hdr.mdata = in.c1.hdr.mdata & ~MDATA_MASK;

    if (!c0_valid || c0_drop) c0_dec = '0;
    if (!in.c1.rspValid || c1_drop) c1_dec = '0;

    drop_sum = {1'b0, drop_cnt} + 17'(c0_drop) + 17'(c1_drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_c0       <= '0;
      s1_c1       <= '0;
      s1_c0_bcast <= 1'b0;
      s1_c0_idx   <= '0;
      s1_c1_idx   <= '0;
      drop_cnt    <= '0;
      drop_err    <= 1'b0;
    end else begin
      s1_c0       <= c0_dec;
      s1_c1       <= c1_dec;
      s1_c0_bcast <= c0_bcast;
      s1_c0_idx   <= c0_idx;
      s1_c1_idx   <= c1_idx;
      drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      drop_err    <= drop_err | c0_drop | c1_drop;
    end
  end

  // almFull is held high in reset so sub-AFUs cannot issue before the pipeline is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SUBAFUS; i++) begin
      if (reset) begin
        out[i]             <= '0;
        out[i].c0TxAlmFull <= 1'b1;
        out[i].c1TxAlmFull <= 1'b1;
      end else begin
        out[i].c0TxAlmFull <= in.c0TxAlmFull | tx_c0_almFull[i];
        out[i].c1TxAlmFull <= in.c1TxAlmFull | tx_c1_almFull[i];
        out[i].c0          <= (s1_c0_bcast || (s1_c0_idx == LOG_N'(i))) ? s1_c0 : '0;
        out[i].c1          <= (s1_c1_idx == LOG_N'(i)) ? s1_c1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_demux.sv
// Directed bench for rx_demux: a 16-port instance for routing and a 12-port instance
// for unroutable-index dropping, both driven from the same Rx stimulus.
module tb_rx_demux;
  import ccip_if_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  t_if_ccip_Rx        rx_in;
  logic [15:0]        tx_c0_af;
  logic [15:0]        tx_c1_af;
  t_if_ccip_Rx        out16 [16];
  t_if_ccip_Rx        out12 [12];
  logic [15:0]        drop_cnt16, drop_cnt12;
  logic               drop_err16, drop_err12;

  logic [15:0] m_c0rsp, m_c1, m_mmiowr, m_mmiord, m_c0af, m_c1af;
  logic [11:0] m12_c0, m12_c1, m12_c0af;

  int n_checks = 0;
  int n_pass   = 0;

  t_ccip_c0_ReqMmioHdr mh;
  t_ccip_c0_RspMemHdr  exp_hdr;

  always #5 clk = ~clk;

  rx_demux #(.N_SUBAFUS(16), .MDATA_IDX_LSB(12), .MMIO_IDX_LSB(12)) dut16 (
    .clk           (clk),
    .reset         (reset),
    .in            (rx_in),
    .tx_c0_almFull (tx_c0_af),
    .tx_c1_almFull (tx_c1_af),
    .out           (out16),
    .drop_cnt      (drop_cnt16),
    .drop_err      (drop_err16)
  );

  rx_demux #(.N_SUBAFUS(12), .MDATA_IDX_LSB(12), .MMIO_IDX_LSB(12)) dut12 (
    .clk           (clk),
    .reset         (reset),
    .in            (rx_in),
    .tx_c0_almFull (tx_c0_af[11:0]),
    .tx_c1_almFull (tx_c1_af[11:0]),
    .out           (out12),
    .drop_cnt      (drop_cnt12),
    .drop_err      (drop_err12)
  );

  always_comb begin
    m_c0rsp = '0; m_c1 = '0; m_mmiowr = '0; m_mmiord = '0; m_c0af = '0; m_c1af = '0;
    m12_c0 = '0; m12_c1 = '0; m12_c0af = '0;
    for (int i = 0; i < 16; i++) begin
      m_c0rsp[i]  = out16[i].c0.rspValid;
      m_c1[i]     = out16[i].c1.rspValid;
      m_mmiowr[i] = out16[i].c0.mmioWrValid;
      m_mmiord[i] = out16[i].c0.mmioRdValid;
      m_c0af[i]   = out16[i].c0TxAlmFull;
      m_c1af[i]   = out16[i].c1TxAlmFull;
    end
    for (int i = 0; i < 12; i++) begin
      m12_c0[i]   = out12[i].c0.rspValid | out12[i].c0.mmioRdValid | out12[i].c0.mmioWrValid;
      m12_c1[i]   = out12[i].c1.rspValid;
      m12_c0af[i] = out12[i].c0TxAlmFull;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rx_in.c0 = '0;
    rx_in.c1 = '0;
  endtask

  initial begin
    reset = 1'b1;
    rx_in = '0;
    tx_c0_af = '0;
    tx_c1_af = '0;
    repeat (3) step();
    check("rst_c0af",    64'(m_c0af), 64'hFFFF);
    check("rst_c1af",    64'(m_c1af), 64'hFFFF);
    check("rst_valid",   64'(m_c0rsp | m_c1 | m_mmiowr | m_mmiord), 64'h0);
    check("rst_dropcnt", 64'(drop_cnt16), 64'h0);
    check("rst_droperr", 64'(drop_err12), 64'h0);
    reset = 1'b0;
    repeat (2) step();
    check("live_c0af", 64'(m_c0af), 64'h0);

    // 1: c0 read response to sub-AFU 3
    rx_in.c0.rspValid      = 1'b1;
    rx_in.c0.hdr.resp_type = eRSP_RDLINE;
    rx_in.c0.hdr.mdata     = 16'h3005;
    rx_in.c0.hdr.cl_num    = 2'd2;
    rx_in.c0.data          = 512'h1234_5678_9ABC_DEF0;
    step(); clear_in();
    check("t1_lat1",  64'(m_c0rsp), 64'h0);
    step();
    check("t1_mask",  64'(m_c0rsp), 64'h0008);
    check("t1_mdata", 64'(out16[3].c0.hdr.mdata), 64'h0005);
    check("t1_clnum", 64'(out16[3].c0.hdr.cl_num), 64'h2);
    check("t1_data",  out16[3].c0.data[63:0], 64'h1234_5678_9ABC_DEF0);
    check("t1_idle0", out16[2].c0.data[63:0], 64'h0);
    check("t1_m12",   64'(m12_c0), 64'h008);
    step();
    check("t1_gone",  64'(m_c0rsp), 64'h0);

    // 2: simultaneous c0 and c1 responses to different ports
    rx_in.c0.rspValid  = 1'b1;
    rx_in.c0.hdr.mdata = 16'h1001;
    rx_in.c1.rspValid  = 1'b1;
    rx_in.c1.hdr.resp_type = eRSP_WRLINE;
    rx_in.c1.hdr.mdata = 16'hE0AA;
    step(); clear_in(); step();
    check("t2_c0mask",  64'(m_c0rsp), 64'h0002);
    check("t2_c1mask",  64'(m_c1), 64'h4000);
    check("t2_c0mdata", 64'(out16[1].c0.hdr.mdata), 64'h0001);
    check("t2_c1mdata", 64'(out16[14].c1.hdr.mdata), 64'h00AA);
    check("t2_c1m12",   64'(m12_c1), 64'h0);
    check("t2_drop12",  64'(drop_cnt12), 64'h1);

    // 3: MMIO write routed by address
    mh = '0;
    mh.address = 16'h2040;
    mh.length  = 2'b01;
    mh.tid     = 9'h155;
    rx_in.c0.hdr = t_ccip_c0_RspMemHdr'(mh);
    rx_in.c0.mmioWrValid = 1'b1;
    rx_in.c0.data = 512'hDEAD;
    step(); clear_in(); step();
    check("t3_wrmask", 64'(m_mmiowr), 64'h0004);
    check("t3_rspmsk", 64'(m_c0rsp | m_mmiord), 64'h0);
    mh = t_ccip_c0_ReqMmioHdr'(out16[2].c0.hdr);
    check("t3_addr",   64'(mh.address), 64'h0040);
    check("t3_tid",    64'(mh.tid), 64'h155);
    check("t3_len",    64'(mh.length), 64'h1);
    check("t3_data",   out16[2].c0.data[63:0], 64'hDEAD);

    // 4: UMsg broadcast, header untouched
    rx_in.c0.rspValid      = 1'b1;
    rx_in.c0.hdr.resp_type = eRSP_UMSG;
    rx_in.c0.hdr.mdata     = 16'h3005;
    rx_in.c0.data          = 512'hCAFE;
    exp_hdr = '0;
    exp_hdr.resp_type = 4'h4;
    exp_hdr.mdata     = 16'h3005;
    step(); clear_in(); step();
    check("t4_mask",   64'(m_c0rsp), 64'hFFFF);
    check("t4_hdr0",   64'(out16[0].c0.hdr), 64'(exp_hdr));
    check("t4_hdr15",  64'(out16[15].c0.hdr), 64'(exp_hdr));
    check("t4_data15", out16[15].c0.data[63:0], 64'hCAFE);
    check("t4_m12",    64'(m12_c0), 64'hFFF);

    // 5: index 13 is unroutable with 12 sub-AFUs
    rx_in.c1.rspValid  = 1'b1;
    rx_in.c1.hdr.mdata = 16'hD000;
    step(); clear_in(); step();
    check("t5_m12c1",   64'(m12_c1), 64'h0);
    check("t5_m16c1",   64'(m_c1), 64'h2000);
    check("t5_mdata16", 64'(out16[13].c1.hdr.mdata), 64'h0);
    check("t5_cnt12",   64'(drop_cnt12), 64'h2);
    check("t5_err12",   64'(drop_err12), 64'h1);
    check("t5_err16",   64'(drop_err16), 64'h0);

    rx_in.c0.rspValid  = 1'b1;
    rx_in.c0.hdr.mdata = 16'hD000;
    rx_in.c1.rspValid  = 1'b1;
    rx_in.c1.hdr.mdata = 16'hD000;
    repeat (10) step();
    clear_in(); step();
    check("t5_cnt_dbl", 64'(drop_cnt12), 64'd22);
    rx_in.c0.rspValid  = 1'b1;
    rx_in.c0.hdr.mdata = 16'hD000;
    rx_in.c1.rspValid  = 1'b1;
    rx_in.c1.hdr.mdata = 16'hD000;
    repeat (32757) step();
    clear_in(); step();
    check("t5_sat",     64'(drop_cnt12), 64'hFFFF);
    rx_in.c1.rspValid  = 1'b1;
    rx_in.c1.hdr.mdata = 16'hD000;
    repeat (100) step();
    clear_in(); step();
    check("t5_sat_hold", 64'(drop_cnt12), 64'hFFFF);
    check("t5_cnt16",    64'(drop_cnt16), 64'h0);

    // 6: per-port almFull merge
    tx_c0_af = 16'h0020;
    step();
    check("t6_c0af",   64'(m_c0af), 64'h0020);
    check("t6_c1af",   64'(m_c1af), 64'h0);
    check("t6_c0af12", 64'(m12_c0af), 64'h020);
    rx_in.c0TxAlmFull = 1'b1;
    tx_c1_af = 16'h8001;
    step();
    check("t6_glob",   64'(m_c0af), 64'hFFFF);
    check("t6_c1af2",  64'(m_c1af), 64'h8001);
    rx_in.c0TxAlmFull = 1'b0;
    tx_c0_af = '0;
    tx_c1_af = '0;
    step();

    // Reset while a response sits in the first stage
    rx_in.c0.rspValid      = 1'b1;
    rx_in.c0.hdr.resp_type = eRSP_RDLINE;
    rx_in.c0.hdr.mdata     = 16'h3005;
    step(); clear_in();
    reset = 1'b1;
    step();
    check("rs_valid",  64'(m_c0rsp), 64'h0);
    check("rs_c0af",   64'(m_c0af), 64'hFFFF);
    check("rs_c1af",   64'(m_c1af), 64'hFFFF);
    check("rs_cnt12",  64'(drop_cnt12), 64'h0);
    check("rs_err12",  64'(drop_err12), 64'h0);
    reset = 1'b0;
    step();
    check("rs_after1", 64'(m_c0rsp), 64'h0);
    step();
    check("rs_after2", 64'(m_c0rsp), 64'h0);
    check("rs_af_low", 64'(m_c0af), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
